ring_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream resource among N requesters, using a one-hot rotating token (ring pointer) to set search priority. It sits in front of the shared datapath. It grants one requester at a time and holds the grant until that requester signals `done` or a hold limit expires. It then advances the token past the served requester so that service stays fair.

---
 rtl/ring_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_ring_rr_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter
//
// Round-robin arbiter sharing one downstream resource among N requesters.
// A one-hot rotating token marks the highest-priority index for the next
// arbitration. A grant is held until the granted requester strobes done or
// the hold limit expires. The token then moves to the index just past the
// served requester.
//
// Parameters:
//   N         number of requesters (>= 2)
//   MAX_HOLD  maximum number of cycles a grant may stay high (>= 1)
//
// Ports:
//   clk      input   rising-edge clock
//   reset    input   synchronous active-high reset
//   req      input   [N]  request vector, bit i = requester i
//   done     input   [N]  completion strobe, only the granted bit is honoured
//   grant    output  [N]  registered grant, one-hot or zero
//   token    output  [N]  registered one-hot ring pointer
//   busy     output  high while a grant is active
//   timeout  output  one-cycle pulse when the hold limit revokes a grant
module ring_rr_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic [N-1:0] done,
    output logic [N-1:0] grant,
    output logic [N-1:0] token,
    output logic         busy,
    output logic         timeout
);

    localparam int unsigned CntW = $clog2(MAX_HOLD + 1);

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [N-1:0]    token_q, token_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;
    logic [CntW-1:0] hold_cnt_q, hold_cnt_d;

    logic [N-1:0] upper_mask;
    logic [N-1:0] req_hi;
    logic [N-1:0] cand;
    logic [N-1:0] pick;
    logic [N-1:0] grant_rot;
    logic         done_hit;
    logic         at_limit;

    // Circular priority search without a loop: first look only at requests at
    // or above the token position; if none, wrap around to the whole vector.
    // The lowest set bit of the chosen vector is the winner.
    always_comb begin
        upper_mask = ~(token_q - N'(1));
        req_hi     = req & upper_mask;
        cand       = (|req_hi) ? req_hi : req;
        pick       = cand & (~cand + N'(1));
        grant_rot  = {grant_q[N-2:0], grant_q[N-1]};
        done_hit   = |(done & grant_q);
        at_limit   = (hold_cnt_q == CntW'(MAX_HOLD));
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        token_d    = token_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            StIdle: begin
                if (|req) begin
                    grant_d    = pick;
                    busy_d     = 1'b1;
                    hold_cnt_d = CntW'(1);
                    state_d    = StGrant;
                end
            end
            StGrant: begin
                if (done_hit || at_limit) begin
                    grant_d    = '0;
                    busy_d     = 1'b0;
                    token_d    = grant_rot;
                    // done wins over the limit when both land on the same edge
                    timeout_d  = ~done_hit;
                    hold_cnt_d = '0;
                    state_d    = StIdle;
                end else begin
                    hold_cnt_d = hold_cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            token_q    <= N'(1);
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            token_q    <= token_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign grant   = grant_q;
    assign token   = token_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Testbench for ring_rr_arbiter (N = 4, MAX_HOLD = 8).
// Each stimulus step pushes the expected post-edge outputs, tagged with the
// cycle they belong to, into a queue; a monitor on the falling edge pops and
// compares them.
module tb_ring_rr_arbiter;

    localparam int unsigned N        = 4;
    localparam int unsigned MAX_HOLD = 8;

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] g;
        logic [3:0] t;
        logic       b;
        logic       to;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] grant;
    logic [N-1:0] token;
    logic         busy;
    logic         timeout;

    exp_t exp_q[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;

    ring_rr_arbiter #(
        .N       (N),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .done   (done),
        .grant  (grant),
        .token  (token),
        .busy   (busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input string field, input logic [3:0] act,
                       input logic [3:0] want);
        n_check++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s.%s @cycle %0d: got %b, expected %b", nm, field, cyc, act, want);
        end
    endtask

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.name, "grant", grant, e.g);
            cmp(e.name, "token", token, e.t);
            cmp(e.name, "busy", {3'b000, busy}, {3'b000, e.b});
            cmp(e.name, "timeout", {3'b000, timeout}, {3'b000, e.to});
        end
    end

    // Drive inputs for the next edge and record the outputs expected after it.
    task automatic step(input string nm, input logic r, input logic [3:0] rq,
                        input logic [3:0] dn, input logic [3:0] eg, input logic [3:0] et,
                        input logic eb, input logic eto);
        exp_t e;
        reset = r;
        req   = rq;
        done  = dn;
        e.cyc  = cyc + 1;
        e.name = nm;
        e.g    = eg;
        e.t    = et;
        e.b    = eb;
        e.to   = eto;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with all requesting
        step("reset0", 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0);
        step("reset1", 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0);

        // Single request, done on third grant cycle
        step("single_g1", 1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0001, 1'b1, 1'b0);
        step("single_g2", 1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0001, 1'b1, 1'b0);
        step("single_g3", 1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0001, 1'b1, 1'b0);
        step("single_rel", 1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b1000, 1'b0, 1'b0);
        step("idle_hold", 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0);
        step("idle_done", 1'b0, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 1'b0, 1'b0);

        // Rotation from a fresh token
        step("rot_reset", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0);
        step("rot_g0", 1'b0, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 1'b1, 1'b0);
        step("rot_r0", 1'b0, 4'b1111, 4'b0001, 4'b0000, 4'b0010, 1'b0, 1'b0);
        step("rot_g1", 1'b0, 4'b1111, 4'b0000, 4'b0010, 4'b0010, 1'b1, 1'b0);
        step("rot_r1", 1'b0, 4'b1111, 4'b0010, 4'b0000, 4'b0100, 1'b0, 1'b0);
        step("rot_g2", 1'b0, 4'b1111, 4'b0000, 4'b0100, 4'b0100, 1'b1, 1'b0);
        step("rot_r2", 1'b0, 4'b1111, 4'b0100, 4'b0000, 4'b1000, 1'b0, 1'b0);
        step("rot_g3", 1'b0, 4'b1111, 4'b0000, 4'b1000, 4'b1000, 1'b1, 1'b0);
        step("rot_r3", 1'b0, 4'b1111, 4'b1000, 4'b0000, 4'b0001, 1'b0, 1'b0);
        step("rot_wrap", 1'b0, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 1'b1, 1'b0);
        step("rot_wrap_r", 1'b0, 4'b1111, 4'b0001, 4'b0000, 4'b0010, 1'b0, 1'b0);

        // Search wraps past N-1 to bit 0 (token at 1, only req 0)
        step("wrap_g", 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0010, 1'b1, 1'b0);
        step("wrap_r", 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 1'b0, 1'b0);
        // Token at 1, req 0 and 3: index 3 comes first in the scan
        step("scan_g", 1'b0, 4'b1001, 4'b0000, 4'b1000, 4'b0010, 1'b1, 1'b0);
        // req drop and foreign done bits do not release
        step("ignore", 1'b0, 4'b0000, 4'b0111, 4'b1000, 4'b0010, 1'b1, 1'b0);
        step("scan_r", 1'b0, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 1'b0, 1'b0);

        // Timeout: grant held exactly MAX_HOLD cycles
        step("to_g1", 1'b0, 4'b0010, 4'b0000, 4'b0010, 4'b0001, 1'b1, 1'b0);
        for (int i = 2; i <= 8; i++) begin
            step("to_hold", 1'b0, 4'b0010, 4'b0000, 4'b0010, 4'b0001, 1'b1, 1'b0);
        end
        step("to_rel", 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b1);
        step("to_clear", 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0);

        // done coincides with the limit: done wins
        step("dl_g1", 1'b0, 4'b0010, 4'b0000, 4'b0010, 4'b0100, 1'b1, 1'b0);
        for (int i = 2; i <= 8; i++) begin
            step("dl_hold", 1'b0, 4'b0010, 4'b0000, 4'b0010, 4'b0100, 1'b1, 1'b0);
        end
        step("dl_rel", 1'b0, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 1'b0, 1'b0);
        step("dl_idle", 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0);

        // Reset in the middle of a grant
        step("mr_g1", 1'b0, 4'b1000, 4'b0000, 4'b1000, 4'b0100, 1'b1, 1'b0);
        step("mr_g2", 1'b0, 4'b1000, 4'b0000, 4'b1000, 4'b0100, 1'b1, 1'b0);
        step("mr_rst", 1'b1, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 1'b0, 1'b0);
        step("mr_regrant", 1'b0, 4'b1000, 4'b0000, 4'b1000, 4'b0001, 1'b1, 1'b0);
        step("mr_rel", 1'b0, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 1'b0, 1'b0);

        // Let the monitor drain every pending expectation
        repeat (2) @(posedge clk);
        #1;
        n_check++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
